// File: rtl/pipelined_regfile_4stage.sv
// Four-stage IF/ID/EXE/WB pipeline over a 32x32 register file with a fixed 16-word ROM.
// WB writes straight out of the EXE/WB register; ID bypass and EXE forward both tap that register.
module pipelined_regfile_4stage (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] aluout_EXE_WB
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  function automatic logic [31:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = {6'd6, 5'd1, 5'd0, 16'd5};
      4'd1:    rom_word = {6'd6, 5'd2, 5'd0, 16'd3};
      4'd2:    rom_word = {6'd1, 5'd3, 5'd1, 5'd2, 11'd0};
      4'd3:    rom_word = {6'd2, 5'd4, 5'd3, 5'd1, 11'd0};
      4'd4:    rom_word = {6'd3, 5'd5, 5'd3, 5'd2, 11'd0};
      4'd5:    rom_word = {6'd4, 5'd6, 5'd3, 5'd2, 11'd0};
      4'd6:    rom_word = {6'd5, 5'd7, 5'd6, 5'd1, 11'd0};
      4'd7:    rom_word = {6'd6, 5'd0, 5'd0, 16'd7};
      4'd8:    rom_word = {6'd1, 5'd8, 5'd0, 5'd4, 11'd0};
      default: rom_word = 32'd0;
    endcase
  endfunction

  logic [3:0]  r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_regs [0:31];

  logic [2:0]  r_ex_op;
  logic [4:0]  r_ex_rd;
  logic [4:0]  r_ex_rs1;
  logic [4:0]  r_ex_rs2;
  logic [31:0] r_ex_a;
  logic [31:0] r_ex_b;
  logic [31:0] r_ex_imm;
  logic        r_ex_we;

  logic [31:0] r_aluout;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;

  logic [5:0]  w_id_opcode;
  logic [4:0]  w_id_rd;
  logic [4:0]  w_id_rs1;
  logic [4:0]  w_id_rs2;
  logic [2:0]  w_id_op;
  logic        w_id_valid;
  logic [31:0] w_id_a;
  logic [31:0] w_id_b;
  logic        w_wb_live;
  logic [31:0] w_ex_a;
  logic [31:0] w_ex_b;
  logic [31:0] w_alu;

  assign w_id_opcode = r_ifid_instr[31:26];
  assign w_id_rd     = r_ifid_instr[25:21];
  assign w_id_rs1    = r_ifid_instr[20:16];
  assign w_id_rs2    = r_ifid_instr[15:11];
  assign w_wb_live   = r_wb_we && (r_wb_rd != 5'd0);

  // Decode; unknown opcodes collapse onto NOP so they never write.
  always_comb begin
    w_id_op    = OP_NOP;
    w_id_valid = 1'b0;
    if ((w_id_opcode >= 6'd1) && (w_id_opcode <= 6'd6)) begin
      w_id_op    = w_id_opcode[2:0];
      w_id_valid = 1'b1;
    end else begin
      w_id_op    = OP_NOP;
      w_id_valid = 1'b0;
    end
  end

  // Register read with same-cycle WB bypass; r0 is hardwired to zero.
  always_comb begin
    w_id_a = 32'd0;
    w_id_b = 32'd0;
    if (w_id_rs1 == 5'd0)                      w_id_a = 32'd0;
    else if (w_wb_live && (r_wb_rd == w_id_rs1)) w_id_a = r_aluout;
    else                                       w_id_a = r_regs[w_id_rs1];
    if (w_id_rs2 == 5'd0)                      w_id_b = 32'd0;
    else if (w_wb_live && (r_wb_rd == w_id_rs2)) w_id_b = r_aluout;
    else                                       w_id_b = r_regs[w_id_rs2];
  end

  // EXE operand forwarding from EXE/WB overrides the value latched in ID/EXE.
  always_comb begin
    w_ex_a = r_ex_a;
    w_ex_b = r_ex_b;
    if (w_wb_live && (r_wb_rd == r_ex_rs1)) w_ex_a = r_aluout;
    else                                    w_ex_a = r_ex_a;
    if (w_wb_live && (r_wb_rd == r_ex_rs2)) w_ex_b = r_aluout;
    else                                    w_ex_b = r_ex_b;
  end

  // ALU, modulo 2^32.
  always_comb begin
    w_alu = 32'd0;
    case (r_ex_op)
      OP_ADD:  w_alu = w_ex_a + w_ex_b;
      OP_SUB:  w_alu = w_ex_a - w_ex_b;
      OP_AND:  w_alu = w_ex_a & w_ex_b;
      OP_OR:   w_alu = w_ex_a | w_ex_b;
      OP_XOR:  w_alu = w_ex_a ^ w_ex_b;
      OP_ADDI: w_alu = w_ex_a + r_ex_imm;
      default: w_alu = 32'd0;
    endcase
  end

  // Pipeline registers and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= 4'd0;
      r_ifid_instr <= 32'd0;
      r_ex_op      <= OP_NOP;
      r_ex_rd      <= 5'd0;
      r_ex_rs1     <= 5'd0;
      r_ex_rs2     <= 5'd0;
      r_ex_a       <= 32'd0;
      r_ex_b       <= 32'd0;
      r_ex_imm     <= 32'd0;
      r_ex_we      <= 1'b0;
      r_aluout     <= 32'd0;
      r_wb_rd      <= 5'd0;
      r_wb_we      <= 1'b0;
    end else begin
      r_pc         <= r_pc + 4'd1;
      r_ifid_instr <= rom_word(r_pc);
      r_ex_op      <= w_id_op;
      r_ex_rd      <= w_id_rd;
      r_ex_rs1     <= w_id_rs1;
      r_ex_rs2     <= (w_id_op == OP_ADDI) ? 5'd0 : w_id_rs2;
      r_ex_a       <= w_id_a;
      r_ex_b       <= w_id_b;
      r_ex_imm     <= {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
      r_ex_we      <= w_id_valid;
      r_aluout     <= w_alu;
      r_wb_rd      <= r_ex_rd;
      r_wb_we      <= r_ex_we;
    end
  end

  // Register file write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_wb_live) begin
      r_regs[r_wb_rd] <= r_aluout;
    end else begin
      r_regs[0] <= 32'd0;
    end
  end

  assign aluout_EXE_WB = r_aluout;

endmodule

// File: tb/tb_pipelined_regfile_4stage.sv
// Directed table-driven bench for pipelined_regfile_4stage: program trace, wrap, r0 and mid-run reset.
module tb_pipelined_regfile_4stage;

  logic        clk;
  logic        rst;
  logic [31:0] aluout_EXE_WB;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_regfile_4stage dut (
    .clk           (clk),
    .rst           (rst),
    .aluout_EXE_WB (aluout_EXE_WB)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:20];
  logic [31:0] exp_regs [1:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  initial begin
    // Expected output after each rising edge following reset release.
    vecs[0]  = '{"edge1_empty", 32'd0};
    vecs[1]  = '{"edge2_empty", 32'd0};
    vecs[2]  = '{"addi_r1",     32'd5};
    vecs[3]  = '{"addi_r2",     32'd3};
    vecs[4]  = '{"add_r3_fwd",  32'd8};
    vecs[5]  = '{"sub_r4_fwd",  32'd3};
    vecs[6]  = '{"and_r5",      32'd0};
    vecs[7]  = '{"or_r6",       32'd11};
    vecs[8]  = '{"xor_r7",      32'd14};
    vecs[9]  = '{"addi_r0",     32'd7};
    vecs[10] = '{"add_r8_r0",   32'd3};
    for (int i = 11; i < 18; i++) vecs[i] = '{"nop_tail", 32'd0};
    vecs[18] = '{"wrap_addi_r1", 32'd5};
    vecs[19] = '{"wrap_addi_r2", 32'd3};
    vecs[20] = '{"wrap_add_r3",  32'd8};
    exp_regs[1] = 32'd5;  exp_regs[2] = 32'd3;  exp_regs[3] = 32'd8;  exp_regs[4] = 32'd3;
    exp_regs[5] = 32'd0;  exp_regs[6] = 32'd11; exp_regs[7] = 32'd14; exp_regs[8] = 32'd3;

    rst = 1'b0;
    #110 rst = 1'b1;
    #1 check("reset_async_out", aluout_EXE_WB, 32'd0);
    #49 rst = 1'b0;   // t=160, first edge after release at 165

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      check(vecs[i].name, aluout_EXE_WB, vecs[i].exp);
    end

    for (int r = 1; r <= 8; r++) check($sformatf("reg_r%0d", r), dut.r_regs[r], exp_regs[r]);
    check("reg_r0", dut.r_regs[0], 32'd0);

    // Output shows 8 here; assert reset between edges.
    #10 rst = 1'b1;
    #1;
    check("midrun_reset_out", aluout_EXE_WB, 32'd0);
    check("midrun_reset_r3", dut.r_regs[3], 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_out", aluout_EXE_WB, 32'd0);
    #20 rst = 1'b0;

    @(posedge clk); #1; check("restart_edge1", aluout_EXE_WB, 32'd0);
    @(posedge clk); #1; check("restart_edge2", aluout_EXE_WB, 32'd0);
    check("restart_no_write_r1", dut.r_regs[1], 32'd0);
    @(posedge clk); #1; check("restart_addi_r1", aluout_EXE_WB, 32'd5);
    @(posedge clk); #1; check("restart_addi_r2", aluout_EXE_WB, 32'd3);
    @(posedge clk); #1; check("restart_add_r3", aluout_EXE_WB, 32'd8);
    @(posedge clk); #1; check("restart_sub_r4", aluout_EXE_WB, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_regfile_4stage.md
PIPELINED_REGFILE_4STAGE -- requirements
Module: pipelined_regfile_4stage

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed: 32-bit datapath, 32 x 32-bit register file, 16-word instruction ROM.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 aluout_EXE_WB  output  32  ALU result held in the EXE/WB pipeline register.

Function
REQ-005 The block SHALL implement 4 stages: IF (PC, ROM read) -> IF/ID reg -> ID (decode, register read) -> ID/EXE reg -> EXE (ALU) -> EXE/WB reg -> WB (register write).
REQ-006 The PC SHALL be a 4-bit word index, increment by 1 each cycle, wrap 15 -> 0, with no branches, stalls or flushes.
REQ-007 Instruction format: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
REQ-008 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (all rd = rs1 op rs2), 6 ADDI (rd = rs1 + sign-extended imm).
REQ-009 Any other opcode SHALL behave as NOP.
REQ-010 ADD, SUB and ADDI SHALL be modulo 2^32; carry and overflow are discarded.
REQ-011 NOP SHALL produce ALU result 0 and no register write.
REQ-012 r0 SHALL always read 0; writes to r0 are discarded, but the ALU result still appears on aluout_EXE_WB.
REQ-013 The WB write SHALL occur on the rising edge following the result's arrival in EXE/WB, using the rd and write-enable carried through the pipeline.
REQ-014 ID bypass: when WB writes register X in the same cycle that ID reads X (X != 0), ID SHALL capture the WB data.
REQ-015 EXE forward: when EXE/WB holds a valid write to X (X != 0) and the instruction in EXE sources X, EXE SHALL use aluout_EXE_WB.
REQ-016 The EXE forward SHALL take priority over the ID/EXE operand value.
REQ-017 Latency: the instruction fetched at PC=n after reset release reaches aluout_EXE_WB after the 3rd rising edge following release and is written on the 4th; throughput is one instruction per cycle.
REQ-018 ROM contents (fixed), words 9-15 are NOP:
 0 ADDI r1,r0,5
 1 ADDI r2,r0,3
 2 ADD r3,r1,r2
 3 SUB r4,r3,r1
 4 AND r5,r3,r2
 5 OR r6,r3,r2
 6 XOR r7,r6,r1
 7 ADDI r0,r0,7
 8 ADD r8,r0,r4
REQ-019 Before the first reset assertion, the output value SHALL be unspecified.

Reset
REQ-020 While rst=1, the block SHALL immediately (no clock required) set PC=0, all pipeline registers to NOP with write-enable 0, aluout_EXE_WB=0, and all 32 registers to 0.
REQ-021 rst asserted mid-program SHALL abort all in-flight instructions with no further register writes.
REQ-022 After rst deasserts, execution SHALL restart from PC=0.

Verification
REQ-023 Bench setup: 30 ns clock; rst low 0-110 ns, high 110-160 ns, then low.
 -> aluout_EXE_WB=0 from 110 ns; on the edges at 225, 255, ... 465 ns it SHALL read 5, 3, 8, 3, 0, 11, 14, 7, 3, then 0 for the following 7 edges.
REQ-024 Forwarding checks: ADD r3 = 8 (exercises EXE forward of r2 and ID bypass of r1); SUB r4 = 3 (exercises EXE forward of r3). With forwarding disabled, these results SHALL differ and the check SHALL fail.
REQ-025 r0 check: ADDI r0 shows 7 on the output, then ADD r8,r0,r4 = 3, i.e. no forwarding or write into r0. After completion, internal r1..r8 = 5,3,8,3,0,11,14,3.
REQ-026 Wrap check: after 16 instructions the PC wraps and the 5, 3, 8, ... sequence repeats identically.
REQ-027 Reset mid-run: assert rst asynchronously between edges while the output shows 8 -> the output goes to 0 before the next edge. After release, the sequence restarts at 5 on the 3rd edge.
